// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one pipelined main memory between I-cache block fills,
//            D-cache block fills and D-side write-through stores.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int WORD_BYTES  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req,
    input  logic [ADDR_W-1:0]              i_addr,
    input  logic                           d_req,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic                           d_wr_req,
    input  logic [ADDR_W-1:0]              d_wdata,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [ADDR_W-1:0]              mem_wdata,
    input  logic                           mem_data_valid,
    input  logic [ADDR_W-1:0]              mem_rdata,
    output logic [ADDR_W-1:0]              fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           i_fill_we,
    output logic                           d_fill_we,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           busy
);

    localparam int c_IDX_W = $clog2(BLOCK_WORDS);
    localparam int c_CNT_W = c_IDX_W + 1;

    localparam logic [ADDR_W-1:0]  c_OFF_MASK  = ADDR_W'(BLOCK_WORDS * WORD_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_BLOCK_CNT = c_CNT_W'(BLOCK_WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(BLOCK_WORDS - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WRITE  = 2'd1;
    localparam logic [1:0] c_FILL_I = 2'd2;
    localparam logic [1:0] c_FILL_D = 2'd3;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [c_CNT_W-1:0] r_issue_cnt;
    logic [c_IDX_W-1:0] r_recv_cnt;

    logic               w_filling;
    logic               w_issuing;
    logic               w_last;
    logic [ADDR_W-1:0]  w_issue_addr;

    assign w_filling    = (r_state == c_FILL_I) || (r_state == c_FILL_D);
    assign w_issuing    = w_filling && (r_issue_cnt < c_BLOCK_CNT);
    assign w_last       = w_filling && mem_data_valid && (r_recv_cnt == c_LAST_IDX);
    // Address arithmetic deliberately wraps at ADDR_W bits.
    assign w_issue_addr = r_base + ADDR_W'(r_issue_cnt) * ADDR_W'(WORD_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (d_wr_req) begin
                        r_state <= c_WRITE;
                    end else if (d_req) begin
                        r_state <= c_FILL_D;
                        r_base  <= d_addr & ~c_OFF_MASK;
                    end else if (i_req) begin
                        r_state <= c_FILL_I;
                        r_base  <= i_addr & ~c_OFF_MASK;
                    end
                end
                c_WRITE: begin
                    r_state <= c_IDLE;
                end
                c_FILL_I, c_FILL_D: begin
                    if (w_issuing) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    if (w_last) begin
                        r_state     <= c_IDLE;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                    end else if (mem_data_valid) begin
                        r_recv_cnt <= r_recv_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Returns that arrive in IDLE or WRITE are stale and dropped here.
    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_data  = '0;
        fill_word  = '0;
        i_fill_we  = 1'b0;
        d_fill_we  = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (r_state)
            c_WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
                d_done     = 1'b1;
            end
            c_FILL_I, c_FILL_D: begin
                if (w_issuing) begin
                    mem_enable = 1'b1;
                    mem_addr   = w_issue_addr;
                end
                if (mem_data_valid) begin
                    fill_data = mem_rdata;
                    fill_word = r_recv_cnt;
                    if (r_state == c_FILL_D) begin
                        d_fill_we = 1'b1;
                        d_done    = w_last;
                    end else begin
                        i_fill_we = 1'b1;
                        i_done    = w_last;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = (r_state != c_IDLE);

endmodule
`default_nettype wire
